// File: rtl/seq_chk_pkg.sv
// Shared definitions for the sequence stream checker.
//   - state_e      : checker FSM states
//   - Def*         : default sequence shape (2..8 step 1, 10..16 step 2, 24,48 doubling)
//   - sat_inc()    : saturating increment for counters up to 32 bits wide
package seq_chk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInc,
    StStp,
    StDbl,
    StDone
  } state_e;

  localparam int unsigned DefW        = 8;
  localparam int unsigned DefInit     = 2;
  localparam int unsigned DefIncEnd   = 8;
  localparam int unsigned DefStep     = 2;
  localparam int unsigned DefStepEnd  = 16;
  localparam int unsigned DefDblStart = 24;
  localparam int unsigned DefDblCount = 2;
  localparam int unsigned DefEcw      = 16;

  // Increment val, sticking at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_expect_gen.sv
// Expected-value generator: walks the three-segment sequence (+1, +STEP, doubling)
// one step per accepted sample.
//   clk, rst        : clock, async active-low reset
//   start           : (re)arm; loads INIT and the doubling-sample budget
//   in_valid        : a sample is presented this cycle
//   exp_data        : value expected for the next accepted sample
//   state           : current FSM state
//   advance         : the presented sample is accepted (compare and step this cycle)
module seq_expect_gen
  import seq_chk_pkg::*;
#(
  parameter int unsigned W         = DefW,
  parameter int unsigned INIT      = DefInit,
  parameter int unsigned INC_END   = DefIncEnd,
  parameter int unsigned STEP      = DefStep,
  parameter int unsigned STEP_END  = DefStepEnd,
  parameter int unsigned DBL_START = DefDblStart,
  parameter int unsigned DBL_COUNT = DefDblCount
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic [W-1:0] exp_data,
  output state_e       state,
  output logic         advance
);

  localparam int unsigned DLW = (DBL_COUNT < 2) ? 1 : $clog2(DBL_COUNT + 1);

  state_e           state_q, state_d;
  logic [W-1:0]     exp_q, exp_d;
  logic [DLW-1:0]   dbl_left_q, dbl_left_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      dbl_left_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      dbl_left_q <= dbl_left_d;
    end
  end

  // A start in the same cycle as a sample wins; that sample is dropped.
  assign advance = in_valid && !start && (state_q inside {StInc, StStp, StDbl});

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    dbl_left_d = dbl_left_q;
    if (start) begin
      state_d    = StInc;
      exp_d      = W'(INIT);
      dbl_left_d = DLW'(DBL_COUNT);
    end else if (advance) begin
      unique case (state_q)
        StInc: begin
          if (exp_q == W'(INC_END)) begin
            state_d = StStp;
            exp_d   = W'(INC_END + STEP);
          end else begin
            exp_d = exp_q + W'(1);
          end
        end
        StStp: begin
          if (exp_q == W'(STEP_END)) begin
            state_d = StDbl;
            exp_d   = W'(DBL_START);
          end else begin
            exp_d = exp_q + W'(STEP);
          end
        end
        StDbl: begin
          dbl_left_d = dbl_left_q - DLW'(1);
          // Last doubling sample: exp_data freezes at the final value.
          if (dbl_left_q == DLW'(1)) begin
            state_d = StDone;
          end else begin
            exp_d = exp_q << 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign exp_data = exp_q;
  assign state    = state_q;

endmodule

// File: rtl/seq_stream_checker.sv
// In-line checker for an 8-bit generated stream: compares every valid sample against
// the internally generated sequence and keeps mismatch statistics.
//   clk, rst   : clock, async active-low reset
//   start      : one-cycle arm/restart pulse
//   in_valid   : in_data holds a sample
//   in_data    : observed stream value
//   exp_data   : value expected for the next valid sample
//   mismatch   : registered one-cycle pulse for a failing sample
//   err_cnt    : saturating mismatch count (ECW <= 32)
//   sample_idx : samples consumed since start, mod 256
//   busy       : armed, sequence not yet complete
//   done       : sequence fully consumed, held until next start
//   pass       : done with no mismatches
module seq_stream_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned W         = DefW,
  parameter int unsigned INIT      = DefInit,
  parameter int unsigned INC_END   = DefIncEnd,
  parameter int unsigned STEP      = DefStep,
  parameter int unsigned STEP_END  = DefStepEnd,
  parameter int unsigned DBL_START = DefDblStart,
  parameter int unsigned DBL_COUNT = DefDblCount,
  parameter int unsigned ECW       = DefEcw
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic [W-1:0]   exp_data,
  output logic           mismatch,
  output logic [ECW-1:0] err_cnt,
  output logic [7:0]     sample_idx,
  output logic           busy,
  output logic           done,
  output logic           pass
);

  if (INIT > INC_END || STEP == 0 || DBL_COUNT < 1 || ECW < 1 || ECW > 32 ||
      STEP_END < INC_END + STEP || ((STEP_END - (INC_END + STEP)) % STEP) != 0)
  begin : g_bad_params
    $error("seq_stream_checker: illegal sequence parameterisation");
  end

  state_e         state;
  logic           advance;

  logic           mismatch_q, mismatch_d;
  logic [ECW-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]     sample_idx_q, sample_idx_d;

  seq_expect_gen #(
    .W         (W),
    .INIT      (INIT),
    .INC_END   (INC_END),
    .STEP      (STEP),
    .STEP_END  (STEP_END),
    .DBL_START (DBL_START),
    .DBL_COUNT (DBL_COUNT)
  ) u_expect_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .exp_data (exp_data),
    .state    (state),
    .advance  (advance)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mismatch_q   <= 1'b0;
      err_cnt_q    <= '0;
      sample_idx_q <= '0;
    end else begin
      mismatch_q   <= mismatch_d;
      err_cnt_q    <= err_cnt_d;
      sample_idx_q <= sample_idx_d;
    end
  end

  always_comb begin
    mismatch_d   = 1'b0;
    err_cnt_d    = err_cnt_q;
    sample_idx_d = sample_idx_q;
    if (start) begin
      err_cnt_d    = '0;
      sample_idx_d = '0;
    end else if (advance) begin
      sample_idx_d = sample_idx_q + 8'd1;
      if (in_data != exp_data) begin
        mismatch_d = 1'b1;
        err_cnt_d  = ECW'(sat_inc(32'(err_cnt_q), ECW));
      end
    end
  end

  assign mismatch   = mismatch_q;
  assign err_cnt    = err_cnt_q;
  assign sample_idx = sample_idx_q;
  assign busy       = state inside {StInc, StStp, StDbl};
  assign done       = (state == StDone);
  assign pass       = done && (err_cnt_q == '0);

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed bench for seq_stream_checker: default build plus an ECW=2 build sharing stimulus.
module tb_seq_stream_checker;

  localparam logic [7:0] VALS [13] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                                       8'd10, 8'd12, 8'd14, 8'd16, 8'd24, 8'd48};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;

  logic [7:0]  exp_data;
  logic        mismatch;
  logic [15:0] err_cnt;
  logic [7:0]  sample_idx;
  logic        busy, done, pass;

  logic [7:0]  s_exp_data;
  logic        s_mismatch;
  logic [1:0]  s_err_cnt;
  logic [7:0]  s_sample_idx;
  logic        s_busy, s_done, s_pass;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_stream_checker u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .exp_data   (exp_data),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt),
    .sample_idx (sample_idx),
    .busy       (busy),
    .done       (done),
    .pass       (pass)
  );

  seq_stream_checker #(.ECW(2)) u_dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .exp_data   (s_exp_data),
    .mismatch   (s_mismatch),
    .err_cnt    (s_err_cnt),
    .sample_idx (s_sample_idx),
    .busy       (s_busy),
    .done       (s_done),
    .pass       (s_pass)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd2;
    tick();
    tick();
    checks++;
    if (exp_data !== 8'd0 || mismatch !== 1'b0 || err_cnt !== 16'd0 || sample_idx !== 8'd0 ||
        busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got exp=%0d mm=%0b err=%0d idx=%0d busy=%0b done=%0b pass=%0b expected all 0",
               exp_data, mismatch, err_cnt, sample_idx, busy, done, pass);
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || sample_idx !== 8'd0) begin
      errors++;
      $display("FAIL idle_ignores_valid: got busy=%0b idx=%0d expected 0 0", busy, sample_idx);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    int mm_seen;
    do_start();
    checks++;
    if (exp_data !== 8'd2 || busy !== 1'b1 || sample_idx !== 8'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_arm: got exp=%0d busy=%0b idx=%0d done=%0b expected 2 1 0 0",
               exp_data, busy, sample_idx, done);
    end
    mm_seen = 0;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data = VALS[i];
      checks++;
      if (exp_data !== VALS[i]) begin
        errors++;
        $display("FAIL basic_exp[%0d]: got %0d expected %0d", i, exp_data, VALS[i]);
      end
      tick();
      if (mismatch !== 1'b0) mm_seen++;
    end
    in_valid = 1'b0;
    checks++;
    if (mm_seen !== 0) begin
      errors++;
      $display("FAIL basic_no_mismatch: got %0d pulses expected 0", mm_seen);
    end
    checks++;
    if (sample_idx !== 8'd13 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL basic_counts: got idx=%0d err=%0d expected 13 0", sample_idx, err_cnt);
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: got done=%0b pass=%0b busy=%0b expected 1 1 0", done, pass, busy);
    end
    // Samples after completion are ignored and exp_data holds.
    in_valid = 1'b1;
    in_data = 8'd99;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (sample_idx !== 8'd13 || exp_data !== 8'd48 || done !== 1'b1 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got idx=%0d exp=%0d done=%0b mm=%0b expected 13 48 1 0",
               sample_idx, exp_data, done, mismatch);
    end
  endtask

  task automatic test_mismatch();
    int mm_count;
    int mm_at;
    do_start();
    mm_count = 0;
    mm_at = -1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data = (i == 8) ? 8'd11 : VALS[i];
      tick();
      if (mismatch === 1'b1) begin
        mm_count++;
        mm_at = i;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (mm_count !== 1 || mm_at !== 8) begin
      errors++;
      $display("FAIL mismatch_pulse: got %0d pulses at sample %0d expected 1 at 8", mm_count, mm_at);
    end
    checks++;
    if (err_cnt !== 16'd1 || done !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_status: got err=%0d done=%0b pass=%0b expected 1 1 0",
               err_cnt, done, pass);
    end
  endtask

  task automatic test_gap();
    do_start();
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data = VALS[i];
      tick();
      if (i == 3) begin
        in_valid = 1'b0;
        in_data = 8'd0;
        for (int g = 0; g < 3; g++) begin
          tick();
          checks++;
          if (exp_data !== 8'd6 || busy !== 1'b1 || mismatch !== 1'b0 || sample_idx !== 8'd4) begin
            errors++;
            $display("FAIL gap_hold[%0d]: got exp=%0d busy=%0b mm=%0b idx=%0d expected 6 1 0 4",
                     g, exp_data, busy, mismatch, sample_idx);
          end
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pass !== 1'b1 || sample_idx !== 8'd13 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL gap_final: got pass=%0b idx=%0d err=%0d expected 1 13 0",
               pass, sample_idx, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = (i == 3) ? 8'd9 : VALS[i];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (mismatch !== 1'b1 || err_cnt !== 16'd1 || sample_idx !== 8'd4) begin
      errors++;
      $display("FAIL pre_reset: got mm=%0b err=%0d idx=%0d expected 1 1 4", mismatch, err_cnt, sample_idx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (exp_data !== 8'd0 || mismatch !== 1'b0 || err_cnt !== 16'd0 || sample_idx !== 8'd0 ||
        busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got exp=%0d mm=%0b err=%0d idx=%0d busy=%0b done=%0b pass=%0b expected all 0",
               exp_data, mismatch, err_cnt, sample_idx, busy, done, pass);
    end
    tick();
    rst = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data = VALS[i];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (pass !== 1'b1 || sample_idx !== 8'd13) begin
      errors++;
      $display("FAIL reset_rerun: got pass=%0b idx=%0d expected 1 13", pass, sample_idx);
    end
  endtask

  task automatic test_restart();
    do_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = VALS[i];
      tick();
    end
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd7;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (exp_data !== 8'd2 || err_cnt !== 16'd0 || sample_idx !== 8'd0 || busy !== 1'b1 ||
        mismatch !== 1'b0) begin
      errors++;
      $display("FAIL restart: got exp=%0d err=%0d idx=%0d busy=%0b mm=%0b expected 2 0 0 1 0",
               exp_data, err_cnt, sample_idx, busy, mismatch);
    end
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data = VALS[i];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (pass !== 1'b1 || sample_idx !== 8'd13) begin
      errors++;
      $display("FAIL restart_rerun: got pass=%0b idx=%0d expected 1 13", pass, sample_idx);
    end
  endtask

  task automatic test_saturate();
    do_start();
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data = VALS[i] + 8'd1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (s_err_cnt !== 2'd3 || s_done !== 1'b1 || s_pass !== 1'b0) begin
      errors++;
      $display("FAIL sat_ecw2: got err=%0d done=%0b pass=%0b expected 3 1 0", s_err_cnt, s_done, s_pass);
    end
    checks++;
    if (err_cnt !== 16'd13 || pass !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL all_wrong_ecw16: got err=%0d pass=%0b done=%0b expected 13 0 1", err_cnt, pass, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_gap();
    test_reset_mid();
    test_restart();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
